cube_state_uart_tx: RTL and testbench
=====================================

Name: cube_state_uart_tx

Overview:
- Reads the 144-bit packed cube_state, as written by the touch-input state block, and transmits it to a host solver over a UART line.
- Snapshots the state on request, then emits one fixed-format ASCII frame, 8N1, LSB first.
- Sits between the cube-state register and the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is 2 or more.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- send_req  input  1  single-cycle request to transmit the current cube_state.
- cube_state  input  144  packed stickers. Sticker i (0..47) occupies bits [(47-i)*3 +: 3], so sticker 0 is in the MSBs.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters 0.
- Reset is synchronous: when sampled high at any edge, it overrides everything.
- Reset mid-frame: transmission aborts. From the next cycle tx=1 and busy=0. No done pulse is generated.
- Frame is 51 bytes, in this order:
  - byte 0: 'S' (0x53).
  - bytes 1..48: sticker 0..47, each sent as ASCII '0'+code (0x30..0x37). Code 0, meaning unassigned, is sent as '0' with no special handling.
  - byte 49: CR (0x0D).
  - byte 50: LF (0x0A).
- Snapshot: cube_state is captured into an internal 144-bit register on the edge where send_req is accepted. Later changes to cube_state do not affect the frame in flight.
- Accept rule: send_req is accepted only when FSM=IDLE and reset=0. It is ignored while busy, and requests are not queued.
- Latency: on the edge after acceptance, busy=1 and tx=0 (start bit of byte 0).
- Byte timing: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
  - There are no idle gaps between bytes: the next start bit follows the previous stop bit immediately.
- Frame duration: exactly 51*10*CLKS_PER_BIT cycles from the first start bit to the end of the last stop bit.
- Completion: on the cycle after the last stop bit's final cycle, done=1 for one cycle, busy=0, tx=1, FSM=IDLE.
  - A send_req on that same cycle is accepted, so back-to-back frames are legal.
- FSM states and transitions:
  - IDLE: on accept, go to LOAD.
  - LOAD: select byte[byte_idx] into the shift register, then go to START. LOAD is merged into the prior edge so that it adds zero cycles.
  - START: after CLKS_PER_BIT cycles, go to DATA.
  - DATA: after 8 bits, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, go to LOAD if byte_idx<50, otherwise to FINISH.
  - FINISH: lasts one cycle (done=1), then IDLE.
- Counters:
  - baud counter: clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps.
  - bit counter: 3 bits.
  - byte_idx: 6 bits, 0..50. It never exceeds 50; a value above 50 forces IDLE.
- Illegal FSM encodings return to IDLE with tx=1.

Decomposition:
- Shared package cube_pkg:
  - NUM_STICKERS=48, COLOUR_W=3, STATE_W=144.
  - colour code typedef (3-bit).
  - FRAME_LEN=51, SOF_CHAR=8'h53, CR/LF constants.
  - sticker extraction function sticker(state,i).
- Sub-module uart_tx_byte: valid/ready byte serializer parameterised by CLKS_PER_BIT.
  - The top holds the frame sequencer, snapshot register and byte mux.
  - ready is asserted in the stop bit's last cycle so that back-to-back bytes are gapless.

Test Plan:
- Default state, CLKS_PER_BIT=4, send_req pulse:
  - decoded bytes = "S", "44444444", "33333333", "77777777", "55555555", "22222222", "66666666", CR, LF;
  - done pulses exactly 2040 cycles after the first start bit;
  - busy then falls.
- Set sticker 0=7 and sticker 47=1, then send:
  - byte1=0x37, byte48=0x31, all other bytes as in the default frame.
- send_req pulses at cycles 10 and 500 of a frame:
  - ignored; exactly one frame of 51 bytes is emitted.
- cube_state changed to all zeros mid-frame:
  - the frame still carries the snapshot values;
  - the next request sends 48 '0' (0x30) sticker bytes.
- Assert reset at byte 20, bit 3:
  - next cycle tx=1 and busy=0, no done pulse;
  - a new send_req then produces a complete, correct frame.
- send_req held high on the done cycle:
  - the second frame starts next cycle with no idle bit period;
  - both frames decode correctly.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared cube definitions: sticker layout, frame characters, FSM state types.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cube_pkg;

    localparam int NUM_STICKERS = 48;
    localparam int COLOUR_W     = 3;
    localparam int STATE_W      = NUM_STICKERS * COLOUR_W;

    // Frame: 'S', 48 sticker digits, CR, LF.
    localparam int FRAME_LEN = 51;
    localparam int LAST_BYTE = FRAME_LEN - 1;

    localparam logic [7:0] SOF_CHAR   = 8'h53;
    localparam logic [7:0] CR_CHAR    = 8'h0D;
    localparam logic [7:0] LF_CHAR    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        FR_IDLE = 2'd0,
        FR_SEND = 2'd1
    } frame_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Sticker 0 lives in the MSBs of the packed state.
    function automatic colour_t sticker(input logic [STATE_W-1:0] state,
                                       input logic [5:0]          idx);
        logic [7:0] lsb;
        lsb = 8'((NUM_STICKERS - 1 - int'(idx)) * COLOUR_W);
        return state[lsb +: COLOUR_W];
    endfunction

    // Byte idx of the outgoing frame, built from a snapshot of the state.
    function automatic logic [7:0] frame_byte(input logic [STATE_W-1:0] snap,
                                             input logic [5:0]          idx);
        logic [7:0] b;
        b = LF_CHAR;
        if (idx == 6'd0) begin
            b = SOF_CHAR;
        end else if (idx <= 6'd48) begin
            b = ASCII_ZERO + {5'd0, sticker(snap, idx - 6'd1)};
        end else if (idx == 6'd49) begin
            b = CR_CHAR;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 LSB-first UART byte serializer, each bit held CLKS_PER_BIT cycles.
// Latency: accepted byte's start bit appears on tx the cycle after the handshake.
// Backpressure: byte_rdy high when idle or in the final cycle of a stop bit, so back-to-back bytes are gapless.
//
// Ports: clk, reset (sync, active high), flush (sync abort to idle),
//        byte_vld/byte_rdy/byte_dat (byte input handshake), tx (serial line, idle high).
module uart_tx_byte
    import cube_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       byte_vld,
    input  logic [7:0] byte_dat,
    output logic       byte_rdy,
    output logic       tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              last_tick;

    assign last_tick = (baud_cnt == BAUD_LAST);
    assign byte_rdy  = (state == TX_IDLE) || ((state == TX_STOP) && last_tick);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state    <= TX_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (byte_vld) begin
                        shreg    <= byte_dat;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (last_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (last_tick) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (last_tick) begin
                        baud_cnt <= '0;
                        // Next byte loads on the stop bit's last edge: no idle gap.
                        if (byte_vld) begin
                            shreg <= byte_dat;
                            tx    <= 1'b0;
                            state <= TX_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/cube_state_uart_tx.sv
// Snapshots the 144-bit cube state on send_req and streams "S" + 48 digits + CR LF over UART 8N1.
// Latency: start bit of byte 0 on tx the cycle after send_req is accepted; done 510*CLKS_PER_BIT cycles later.
// Backpressure: send_req ignored (not queued) while a frame is in flight; accepted again on the done cycle.
//
// Ports: clk, reset (sync, active high), send_req (1-cycle request), cube_state (packed stickers),
//        tx (UART line, idle high), busy (frame in progress), done (1-cycle completion pulse).
module cube_state_uart_tx
    import cube_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               send_req,
    input  logic [STATE_W-1:0] cube_state,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    frame_state_t       fstate;
    logic [5:0]         byte_idx;   // byte currently held by the serializer
    logic [STATE_W-1:0] snap;

    logic       accept;
    logic       in_send;
    logic       bad_idx;
    logic       flush;
    logic [5:0] sel_idx;
    logic       byte_vld;
    logic       byte_rdy;
    logic [7:0] byte_dat;

    assign accept  = (fstate == FR_IDLE) && send_req;
    assign in_send = (fstate == FR_SEND);
    assign bad_idx = (byte_idx > 6'(LAST_BYTE));

    // The load step is folded into the handshake edge: on accept the mux
    // presents byte 0 directly, otherwise it presents the byte after the one
    // being shifted, which the serializer takes on its stop bit's last cycle.
    always_comb begin
        sel_idx  = in_send ? (byte_idx + 6'd1) : 6'd0;
        byte_vld = accept || (in_send && (byte_idx < 6'(LAST_BYTE)));
        byte_dat = frame_byte(snap, sel_idx);
        flush    = ((fstate != FR_IDLE) && (fstate != FR_SEND)) || (in_send && bad_idx);
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .byte_vld (byte_vld),
        .byte_dat (byte_dat),
        .byte_rdy (byte_rdy),
        .tx       (tx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fstate   <= FR_IDLE;
            byte_idx <= '0;
            snap     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fstate)
                FR_IDLE: begin
                    if (send_req) begin
                        snap     <= cube_state;
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        fstate   <= FR_SEND;
                    end
                end
                FR_SEND: begin
                    if (bad_idx) begin
                        byte_idx <= '0;
                        busy     <= 1'b0;
                        fstate   <= FR_IDLE;
                    end else if (byte_rdy) begin
                        // byte_rdy here marks the last cycle of the current stop bit.
                        if (byte_idx == 6'(LAST_BYTE)) begin
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            fstate <= FR_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 6'd1;
                        end
                    end
                end
                default: begin
                    byte_idx <= '0;
                    busy     <= 1'b0;
                    fstate   <= FR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cube_state_uart_tx.sv
// Scoreboard bench for cube_state_uart_tx: stimulus pushes expected frame bytes,
// a UART-decoding monitor pops and compares each received byte.
module tb_cube_state_uart_tx;

    localparam int C         = 4;
    localparam int HALF      = C / 2;
    localparam int FRAME_CYC = 51 * 10 * C;

    typedef logic [2:0] codes_t [48];

    logic         clk = 1'b0;
    logic         reset;
    logic         send_req;
    logic [143:0] cube_state;
    logic         tx;
    logic         busy;
    logic         done;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int rx_cnt   = 0;
    logic [7:0] exp_q [$];

    cube_state_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .send_req   (send_req),
        .cube_state (cube_state),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    function automatic logic [143:0] pack(input codes_t c);
        logic [143:0] s;
        s = '0;
        for (int i = 0; i < 48; i++) s[(47 - i) * 3 +: 3] = c[i];
        return s;
    endfunction

    function automatic codes_t def_codes();
        codes_t c;
        logic [2:0] face [6];
        face = '{3'd4, 3'd3, 3'd7, 3'd5, 3'd2, 3'd6};
        for (int i = 0; i < 48; i++) c[i] = face[i / 8];
        return c;
    endfunction

    task automatic push_frame(input codes_t c);
        exp_q.push_back(8'h53);
        for (int i = 0; i < 48; i++) exp_q.push_back(8'h30 + {5'd0, c[i]});
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Returns at the negedge of the done cycle, or -1 after a bounded wait.
    task automatic wait_done(input string tag, output int t);
        bit seen;
        seen = 1'b0;
        t = -1;
        for (int i = 0; i < FRAME_CYC + 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no done expected done pulse", tag);
        end
    endtask

    task automatic run_frame(input string tag, input codes_t c);
        int t0, td, r0;
        r0 = rx_cnt;
        cube_state = pack(c);
        push_frame(c);
        pulse_req();
        t0 = cyc;
        chk({tag, "_lat_busy"}, 32'(busy), 32'd1);
        chk({tag, "_lat_tx"}, 32'(tx), 32'd0);
        wait_done(tag, td);
        chk({tag, "_frame_len"}, 32'(td - t0), 32'(FRAME_CYC));
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_tx"}, 32'(tx), 32'd1);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_rx_count"}, 32'(rx_cnt - r0), 32'd51);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // UART monitor: detects the start edge, samples each bit mid-period.
    initial begin
        logic [9:0] bits;
        logic [7:0] e;
        bit aborted;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || tx !== 1'b0) continue;
            aborted = 1'b0;
            bits = '0;
            for (int k = 0; k < 10; k++) begin
                for (int j = 0; j < ((k == 0) ? HALF : C); j++) begin
                    @(negedge clk);
                    if (reset === 1'b1) aborted = 1'b1;
                end
                bits[k] = tx;
                if (aborted) break;
            end
            if (!aborted) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no byte", bits[8:1]);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rx_byte_%0d", rx_cnt), {22'd0, bits}, {22'd0, 1'b1, e, 1'b0});
                end
            end
        end
    end

    initial begin
        codes_t dflt, edit, zero;
        int t0, td, td2, r0, d0;

        dflt = def_codes();
        edit = dflt;
        edit[0]  = 3'd7;
        edit[47] = 3'd1;
        for (int i = 0; i < 48; i++) zero[i] = 3'd0;

        reset = 1'b1;
        send_req = 1'b0;
        cube_state = '0;
        repeat (3) tick();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_tx", 32'(tx), 32'd1);

        // Default colour layout.
        run_frame("default", dflt);

        // Sticker 0 = 7, sticker 47 = 1.
        run_frame("edit", edit);

        // Requests at cycles 10 and 500 of a frame are ignored.
        r0 = rx_cnt;
        cube_state = pack(dflt);
        push_frame(dflt);
        pulse_req();
        t0 = cyc;
        repeat (9) tick();
        pulse_req();
        while (cyc < t0 + 499) tick();
        pulse_req();
        wait_done("ignore", td);
        chk("ignore_frame_len", 32'(td - t0), 32'(FRAME_CYC));
        repeat (100) tick();
        chk("ignore_busy", 32'(busy), 32'd0);
        chk("ignore_tx", 32'(tx), 32'd1);
        chk("ignore_rx_count", 32'(rx_cnt - r0), 32'd51);
        chk("ignore_queue", 32'(exp_q.size()), 32'd0);

        // State changes mid-frame do not affect the snapshot.
        cube_state = pack(dflt);
        push_frame(dflt);
        pulse_req();
        t0 = cyc;
        repeat (300) tick();
        cube_state = '0;
        wait_done("snap", td);
        chk("snap_frame_len", 32'(td - t0), 32'(FRAME_CYC));
        tick();
        run_frame("zeros", zero);

        // Reset during data bit 3 of byte 20.
        d0 = done_cnt;
        cube_state = pack(dflt);
        push_frame(dflt);
        pulse_req();
        t0 = cyc;
        while (cyc < t0 + 817) tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_left", 32'(exp_q.size()), 32'd31);
        reset = 1'b0;
        exp_q.delete();
        repeat (20) tick();
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_idle_busy", 32'(busy), 32'd0);
        run_frame("after_reset", dflt);

        // Request held high through the done cycle: second frame starts at once.
        cube_state = pack(dflt);
        push_frame(dflt);
        push_frame(edit);
        pulse_req();
        t0 = cyc;
        repeat (1000) tick();
        send_req = 1'b1;
        cube_state = pack(edit);
        wait_done("b2b_a", td);
        chk("b2b_a_frame_len", 32'(td - t0), 32'(FRAME_CYC));
        chk("b2b_a_done_tx", 32'(tx), 32'd1);
        tick();
        send_req = 1'b0;
        t0 = cyc;
        chk("b2b_start_busy", 32'(busy), 32'd1);
        chk("b2b_start_tx", 32'(tx), 32'd0);
        wait_done("b2b_b", td2);
        chk("b2b_b_frame_len", 32'(td2 - t0), 32'(FRAME_CYC));
        repeat (5) tick();
        chk("b2b_queue", 32'(exp_q.size()), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
